// File: rtl/preg_free_list_ctrl_pkg.sv
// preg_free_list_ctrl_pkg: shared sizes and pointer types for the physical-register free list
package preg_free_list_ctrl_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int NUM_TAGS  = 4;
  typedef logic [$clog2(NUM_PREGS)-1:0] preg_t;
  typedef logic [$clog2(NUM_PREGS):0]   fl_ptr_t;
  typedef logic [$clog2(NUM_TAGS)-1:0]  tag_t;
endpackage

// File: rtl/preg_free_list_ctrl_ckpt_table.sv
// preg_free_list_ctrl_ckpt_table: per-branch-tag head snapshots, 1 write / 1 read port
//   clk, rst   clock, synchronous active-high reset (all snapshots cleared)
//   we_i       write wdata_i into slot wtag_i
//   rtag_i     read slot select; rdata_o is combinational
module preg_free_list_ctrl_ckpt_table
  import preg_free_list_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    we_i,
  input  tag_t    wtag_i,
  input  fl_ptr_t wdata_i,
  input  tag_t    rtag_i,
  output fl_ptr_t rdata_o
);
  fl_ptr_t ckpt_q [NUM_TAGS];
  always_ff @(posedge clk)
    if (rst)
      for (int t = 0; t < NUM_TAGS; t++) ckpt_q[t] <= '0;
    else if (we_i)
      ckpt_q[wtag_i] <= wdata_i;
  assign rdata_o = ckpt_q[rtag_i];
endmodule

// File: rtl/preg_free_list_ctrl.sv
// preg_free_list_ctrl: circular free list of physical registers with branch-tag head rollback
//   alloc_req/alloc_preg/empty        rename dequeue; alloc_preg is the current head entry
//   free_we/free_preg                 commit release of an old mapping (preg 0 ignored)
//   ckpt_we/ckpt_tag                  snapshot post-allocation head for a renamed branch
//   br_broadcast/br_kill/br_tag       branch resolution; kill restores the tag's head
//   free_count                        tail - head
module preg_free_list_ctrl
  import preg_free_list_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    alloc_req,
  output preg_t   alloc_preg,
  output logic    empty,
  input  logic    free_we,
  input  preg_t   free_preg,
  input  logic    ckpt_we,
  input  tag_t    ckpt_tag,
  input  logic    br_broadcast,
  input  logic    br_kill,
  input  tag_t    br_tag,
  output fl_ptr_t free_count
);
  localparam int PW = $clog2(NUM_PREGS);
  preg_t   mem_q [NUM_PREGS];
  fl_ptr_t head_q, head_d, tail_q, tail_d, ckpt_rd, ckpt_wd, rb_dist;
  logic    full, do_alloc, do_free, kill;
  assign free_count = tail_q - head_q;
  assign empty      = head_q == tail_q;
  assign full       = free_count == fl_ptr_t'(NUM_PREGS);
  assign alloc_preg = mem_q[head_q[PW-1:0]];
  assign kill       = br_broadcast & br_kill;
  assign do_alloc   = alloc_req & ~empty;
  assign do_free    = free_we & (free_preg != '0) & ~full;
  // head as it stands after this cycle's own allocation; a branch that
  // allocates must not roll back onto its own destination preg
  assign ckpt_wd    = head_q + fl_ptr_t'(do_alloc);
  assign head_d     = kill ? ckpt_rd : ckpt_wd;
  assign tail_d     = tail_q + fl_ptr_t'(do_free);
  assign rb_dist    = head_q - ckpt_rd;
  always_ff @(posedge clk)
    if (rst) begin
      head_q <= '0;
      tail_q <= fl_ptr_t'(NUM_PREGS - NUM_AREGS);
      for (int i = 0; i < NUM_PREGS; i++)
        mem_q[i] <= i < NUM_PREGS - NUM_AREGS ? preg_t'(NUM_AREGS + i) : '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (do_free) mem_q[tail_q[PW-1:0]] <= free_preg;
    end
  // a branch renamed in the kill cycle is younger than the killer, so its snapshot is dropped
  preg_free_list_ctrl_ckpt_table u_ckpt (
    .clk    (clk),
    .rst    (rst),
    .we_i   (ckpt_we & ~kill),
    .wtag_i (ckpt_tag),
    .wdata_i(ckpt_wd),
    .rtag_i (br_tag),
    .rdata_o(ckpt_rd)
  );
  a_count_bound: assert property (@(posedge clk) disable iff (rst) free_count <= fl_ptr_t'(NUM_PREGS));
  a_restore_range: assert property (@(posedge clk) disable iff (rst) kill |-> rb_dist <= fl_ptr_t'(NUM_PREGS));
  a_alloc_empty: assert property (@(posedge clk) disable iff (rst) !(alloc_req && empty))
    else $warning("alloc_req while empty ignored");
  a_free_full: assert property (@(posedge clk) disable iff (rst) !(free_we && free_preg != '0 && full))
    else $warning("free while full dropped");
endmodule
